slice_controller: RTL

Frame-rate sequencer that decides when the katana has cut the active veggie and drives the `split` signal consumed by the slice-angle datapath and the sprite-splitting logic. Once per video frame it samples the katana position, derives swipe speed from the previous frame's sample, checks the veggie hitbox, and runs a small FSM (armed / split / release) that asserts `split_out`, holds it for a fixed number of frames, then re-arms once the katana has left the veggie. It also emits a one-cycle slice pulse and a saturating slice counter for the score logic.

---
 rtl/slice_controller.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/slice_controller.sv
// slice_controller
//   Frame-rate slice sequencer. Once per video frame (tick at hcount 1024,
//   vcount 768) it samples the katana position, derives Manhattan swipe speed
//   against the previous frame's sample, tests the veggie hitbox and runs an
//   ARMED / SPLIT / RELEASE FSM that drives split_out for HOLD_FRAMES frames.
//
// Ports
//   clk_in        pixel clock
//   rst_n_in      asynchronous active-low reset
//   hcount_in     horizontal pixel count (11b)
//   vcount_in     vertical line count (10b)
//   katana_x/y    katana position (11b / 10b)
//   veggie_x/y    veggie hitbox top-left (11b / 10b)
//   veggie_valid  veggie present and sliceable
//   split_out     veggie is split
//   slice_pulse   one-cycle strobe per new slice
//   slice_count   saturating slice counter (8b)
//   state_out     FSM state: 0 ARMED, 1 SPLIT, 2 RELEASE
module slice_controller #(
  parameter int unsigned SPEED_THRESH = 8,
  parameter int unsigned FAST_FRAMES  = 2,
  parameter int unsigned HOLD_FRAMES  = 60,
  parameter int unsigned HIT_SIZE     = 64
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [10:0] katana_x,
  input  logic [9:0]  katana_y,
  input  logic [10:0] veggie_x,
  input  logic [9:0]  veggie_y,
  input  logic        veggie_valid,
  output logic        split_out,
  output logic        slice_pulse,
  output logic [7:0]  slice_count,
  output logic [1:0]  state_out
);

  localparam logic [1:0] ARMED   = 2'd0;
  localparam logic [1:0] SPLIT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  localparam logic [3:0]  FAST_LAST = 4'(FAST_FRAMES - 1);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_FRAMES - 1);
  localparam logic [11:0] THRESH    = 12'(SPEED_THRESH);

  logic [1:0]  state, state_nxt;
  logic [3:0]  fast_cnt, fast_nxt;
  logic [7:0]  hold_cnt, hold_nxt;
  logic [10:0] prev_x;
  logic [9:0]  prev_y;
  logic        prev_valid;

  logic        tick;
  logic [10:0] dx;
  logic [9:0]  dy;
  logic [11:0] speed;
  logic [11:0] x_lim;
  logic [10:0] y_lim;
  logic        fast;
  logic        in_box;
  logic        qualify;

  always_comb begin
    tick    = (hcount_in == 11'd1024) && (vcount_in == 10'd768);
    dx      = (katana_x >= prev_x) ? katana_x - prev_x : prev_x - katana_x;
    dy      = (katana_y >= prev_y) ? katana_y - prev_y : prev_y - katana_y;
    speed   = prev_valid ? ({1'b0, dx} + {2'b00, dy}) : '0;
    fast    = speed >= THRESH;
    // Upper bounds widened by one bit so the hitbox never wraps at screen edge
    x_lim   = {1'b0, veggie_x} + 12'(HIT_SIZE);
    y_lim   = {1'b0, veggie_y} + 11'(HIT_SIZE);
    in_box  = (katana_x >= veggie_x) && ({1'b0, katana_x} < x_lim) &&
              (katana_y >= veggie_y) && ({1'b0, katana_y} < y_lim);
    qualify = veggie_valid && in_box && fast;
  end

  always_comb begin
    state_nxt = state;
    fast_nxt  = fast_cnt;
    hold_nxt  = hold_cnt;
    case (state)
      ARMED: begin
        if (tick) begin
          if (qualify) begin
            if (fast_cnt == FAST_LAST) begin
              state_nxt = SPLIT;
              fast_nxt  = '0;
              hold_nxt  = '0;
            end else begin
              fast_nxt = fast_cnt + 4'd1;
            end
          end else begin
            fast_nxt = '0;
          end
        end else if (!veggie_valid) begin
          fast_nxt = '0;
        end
      end
      SPLIT: begin
        // Losing the veggie overrides the hold timer on any cycle
        if (!veggie_valid) begin
          state_nxt = RELEASE;
        end else if (tick) begin
          if (hold_cnt == HOLD_LAST) state_nxt = RELEASE;
          else                       hold_nxt  = hold_cnt + 8'd1;
        end
      end
      RELEASE: begin
        if (tick && (!in_box || !veggie_valid)) begin
          state_nxt = ARMED;
          fast_nxt  = '0;
        end
      end
      default: state_nxt = ARMED;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= ARMED;
      fast_cnt    <= '0;
      hold_cnt    <= '0;
      prev_x      <= '0;
      prev_y      <= '0;
      prev_valid  <= 1'b0;
      split_out   <= 1'b0;
      slice_pulse <= 1'b0;
      slice_count <= '0;
    end else begin
      state       <= state_nxt;
      fast_cnt    <= fast_nxt;
      hold_cnt    <= hold_nxt;
      split_out   <= (state_nxt == SPLIT);
      slice_pulse <= (state == ARMED) && (state_nxt == SPLIT);
      if ((state == ARMED) && (state_nxt == SPLIT) && (slice_count != '1))
        slice_count <= slice_count + 8'd1;
      if (tick) begin
        prev_x     <= katana_x;
        prev_y     <= katana_y;
        prev_valid <= 1'b1;
      end
    end
  end

  assign state_out = state;

endmodule
